// File: rtl/stable_value_reporter_if.sv
// Handshake bundle between the stability-count source, the reporter and its consumer.
// The reporter binds to the slave modport; the driving/consuming side uses master.
interface stable_value_reporter_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    in_val;
    logic [7:0]    in_cnt;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    drop_cnt;
    logic [LW-1:0] fifo_level;

    modport slave (
        input  in_val, in_cnt, out_ready,
        output out_data, out_valid, drop_cnt, fifo_level
    );

    modport master (
        output in_val, in_cnt, out_ready,
        input  out_data, out_valid, drop_cnt, fifo_level
    );
endinterface

// File: rtl/stable_value_reporter.sv
// Turns a value plus its stability run length into "value settled" events,
// queued in a small FIFO and drained over a valid/ready handshake.
module stable_value_reporter #(
    parameter int STABLE_CNT = 3,
    parameter int DEPTH      = 4,
    parameter int DEDUP      = 1
) (
    input logic               clk,
    input logic               rst,
    stable_value_reporter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {ARM, WAIT_CHANGE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    last_q, last_d;
    logic          has_q, has_d;
    logic          stable_event;
    logic          suppress;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;

    // One event per run: fire on reaching the threshold, then wait for the count to restart.
    always_comb begin
        state_d      = state_q;
        stable_event = 1'b0;
        case (state_q)
            ARM: begin
                if (bus.in_cnt == 8'(STABLE_CNT)) begin
                    stable_event = 1'b1;
                    state_d      = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                if (bus.in_cnt == 8'd0) begin
                    state_d = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        suppress = (DEDUP != 0) && has_q && (bus.in_val == last_q);
        push     = stable_event && !suppress;
        pop      = (level_q != '0) && bus.out_ready;
        full     = (level_q == LW'(DEPTH));
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        accept   = push && (!full || pop);

        rd_ptr_d = pop    ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;

        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!accept && pop) begin
            level_d = level_q - LW'(1);
        end

        drop_d = drop_q;
        if (push && !accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        last_d = last_q;
        has_d  = has_q;
        if (push) begin
            last_d = bus.in_val;
            has_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARM;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 8'd0;
            last_q   <= 8'd0;
            has_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            last_q   <= last_d;
            has_q    <= has_d;
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wr_ptr_q] <= bus.in_val;
        end
    end

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.drop_cnt   = drop_q;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_stable_value_reporter.sv
// Drives a DEDUP=1 and a DEDUP=0 reporter with identical stimulus and compares
// both against a queue-based reference of the settled-value reporting rules.
module tb_stable_value_reporter;
    localparam int STABLE_CNT = 3;
    localparam int DEPTH      = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stable_value_reporter_if #(.DEPTH(DEPTH)) bus1 ();
    stable_value_reporter_if #(.DEPTH(DEPTH)) bus0 ();

    stable_value_reporter #(.STABLE_CNT(STABLE_CNT), .DEPTH(DEPTH), .DEDUP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    stable_value_reporter #(.STABLE_CNT(STABLE_CNT), .DEPTH(DEPTH), .DEDUP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state per instance: index 1 deduplicates, index 0 does not.
    logic [7:0] mq [2][$];
    int         mDrop [2];
    bit         mReported [2];
    bit         mHasRep [2];
    logic [7:0] mLast [2];

    typedef struct {
        logic [7:0] val;
        logic [7:0] cnt;
        logic       rdy;
        logic       rs;
        logic       expValid;
        logic [7:0] expData;
        logic [2:0] expLevel;
        logic [7:0] expDrop;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic [7:0] v, input logic [7:0] c, input logic r, input logic rs);
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                mq[i].delete();
                mDrop[i]     = 0;
                mReported[i] = 0;
                mHasRep[i]   = 0;
                mLast[i]     = 8'h00;
            end else begin
                bit ev;
                bit doPop;
                ev    = 0;
                doPop = (mq[i].size() > 0) && r;
                if (mReported[i]) begin
                    if (c == 8'd0) mReported[i] = 0;
                end else if (c == 8'(STABLE_CNT)) begin
                    ev           = 1;
                    mReported[i] = 1;
                end
                if (ev && !((i == 1) && mHasRep[i] && (v == mLast[i]))) begin
                    mLast[i]   = v;
                    mHasRep[i] = 1;
                    if (doPop) void'(mq[i].pop_front());
                    doPop = 0;
                    if (mq[i].size() < DEPTH) mq[i].push_back(v);
                    else if (mDrop[i] < 255) mDrop[i]++;
                end
                if (doPop) void'(mq[i].pop_front());
            end
        end
    endtask

    task automatic compareModels();
        logic [7:0] expData [2];
        for (int i = 0; i < 2; i++) expData[i] = (mq[i].size() > 0) ? mq[i][0] : 8'h00;
        checkOutput("d1.valid", 32'(bus1.out_valid), 32'(mq[1].size() > 0));
        checkOutput("d1.data", 32'(bus1.out_data), 32'(expData[1]));
        checkOutput("d1.level", 32'(bus1.fifo_level), 32'(mq[1].size()));
        checkOutput("d1.drop", 32'(bus1.drop_cnt), 32'(mDrop[1]));
        checkOutput("d0.valid", 32'(bus0.out_valid), 32'(mq[0].size() > 0));
        checkOutput("d0.data", 32'(bus0.out_data), 32'(expData[0]));
        checkOutput("d0.level", 32'(bus0.fifo_level), 32'(mq[0].size()));
        checkOutput("d0.drop", 32'(bus0.drop_cnt), 32'(mDrop[0]));
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic [7:0] c, input logic r, input logic rs);
        bus1.in_val    = v;
        bus1.in_cnt    = c;
        bus1.out_ready = r;
        bus0.in_val    = v;
        bus0.in_cnt    = c;
        bus0.out_ready = r;
        rst            = rs;
        @(posedge clk);
        modelStep(v, c, r, rs);
        #1;
        compareModels();
    endtask

    task automatic stabilise(input logic [7:0] v, input logic r);
        for (int c = 0; c <= STABLE_CNT; c++) applyStimulus(v, 8'(c), r, 1'b0);
    endtask

    initial begin
        logic [7:0] rv;
        logic [7:0] rc;
        logic [7:0] nv;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus1.in_val = 8'h00; bus1.in_cnt = 8'h00; bus1.out_ready = 1'b0;
        bus0.in_val = 8'h00; bus0.in_cnt = 8'h00; bus0.out_ready = 1'b0;

        // Basic event: one push on reaching the threshold, none afterwards.
        vecs[0] = '{8'h11, 8'd0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
        vecs[1] = '{8'h11, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0};
        vecs[2] = '{8'h11, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0};
        vecs[3] = '{8'h11, 8'd2, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0};
        vecs[4] = '{8'h11, 8'd3, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 8'd0};
        vecs[5] = '{8'h11, 8'd4, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 8'd0};
        vecs[6] = '{8'h11, 8'd5, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 8'd0};
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k].val, vecs[k].cnt, vecs[k].rdy, vecs[k].rs);
            checkOutput($sformatf("vec%0d.valid", k), 32'(bus1.out_valid), 32'(vecs[k].expValid));
            checkOutput($sformatf("vec%0d.data", k), 32'(bus1.out_data), 32'(vecs[k].expData));
            checkOutput($sformatf("vec%0d.level", k), 32'(bus1.fifo_level), 32'(vecs[k].expLevel));
            checkOutput($sformatf("vec%0d.drop", k), 32'(bus1.drop_cnt), 32'(vecs[k].expDrop));
        end

        // Full FIFO drops the fifth value, then drains in order.
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) stabilise(8'(k), 1'b0);
        checkOutput("full.level", 32'(bus1.fifo_level), 32'd4);
        checkOutput("full.drop", 32'(bus1.drop_cnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain%0d.data", k), 32'(bus1.out_data), 32'(k + 1));
            applyStimulus(8'h05, 8'(4 + k), 1'b1, 1'b0);
        end
        checkOutput("drained.valid", 32'(bus1.out_valid), 32'd0);

        // Deduplication across a short bounce.
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b1);
        stabilise(8'hA5, 1'b0);
        applyStimulus(8'h3C, 8'd0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 8'd1, 1'b0, 1'b0);
        stabilise(8'hA5, 1'b0);
        checkOutput("dedup.d1.level", 32'(bus1.fifo_level), 32'd1);
        checkOutput("dedup.d0.level", 32'(bus0.fifo_level), 32'd2);

        // Counter wrap re-arms the event.
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b1);
        for (int c = 0; c < 256; c++) applyStimulus(8'h77, 8'(c), 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) applyStimulus(8'h77, 8'(c), 1'b0, 1'b0);
        checkOutput("wrap.d1.level", 32'(bus1.fifo_level), 32'd1);
        checkOutput("wrap.d0.level", 32'(bus0.fifo_level), 32'd2);

        // Push and pop together while full.
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) stabilise(8'(k), 1'b0);
        for (int c = 0; c < STABLE_CNT; c++) applyStimulus(8'h99, 8'(c), 1'b0, 1'b0);
        applyStimulus(8'h99, 8'(STABLE_CNT), 1'b1, 1'b0);
        checkOutput("pushpop.level", 32'(bus1.fifo_level), 32'd4);
        checkOutput("pushpop.drop", 32'(bus1.drop_cnt), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) checkOutput("pushpop.last", 32'(bus1.out_data), 32'h99);
            applyStimulus(8'h99, 8'(4 + k), 1'b1, 1'b0);
        end

        // Reset mid-operation clears queue, drops and dedup history.
        applyStimulus(8'h00, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) stabilise(8'(k), 1'b0);
        applyStimulus(8'h06, 8'd4, 1'b1, 1'b0);
        checkOutput("prerst.level", 32'(bus1.fifo_level), 32'd3);
        checkOutput("prerst.drop", 32'(bus1.drop_cnt), 32'd2);
        applyStimulus(8'h06, 8'd5, 1'b0, 1'b1);
        checkOutput("rst.valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("rst.data", 32'(bus1.out_data), 32'd0);
        checkOutput("rst.level", 32'(bus1.fifo_level), 32'd0);
        checkOutput("rst.drop", 32'(bus1.drop_cnt), 32'd0);
        stabilise(8'h00, 1'b0);
        checkOutput("postrst.level", 32'(bus1.fifo_level), 32'd1);
        checkOutput("postrst.valid", 32'(bus1.out_valid), 32'd1);

        // Randomised traffic shaped like a real bouncing bus.
        rv = 8'h00;
        rc = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            nv = rv;
            if ($urandom_range(0, 3) == 0) nv = 8'($urandom_range(0, 3));
            if (nv != rv) rc = 8'h00;
            else rc = rc + 8'd1;
            if ($urandom_range(0, 49) == 0) rc = 8'($urandom_range(0, 255));
            rv = nv;
            applyStimulus(rv, rc, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stable_value_reporter.md
Name: stable_value_reporter

Overview:
- Downstream consumer of the per-clock stability counter, which reports how many consecutive rising edges an 8-bit value has stayed unchanged.
- Watches the counter together with the value it tracks. Each time the count reaches a programmed threshold, the block captures that now-stable value.
- Captured values are queued in a small FIFO and presented to the next stage over a valid/ready handshake.
- Used to turn raw, possibly bouncing bus values into clean "value settled" events.

Parameters:
- STABLE_CNT, 3: run length at which a value is declared stable. Legal range 1..255.
- DEPTH, 4: FIFO entries. Must be a power of 2, 2..16.
- DEDUP, 1: when 1, a stable value equal to the last reported value is not queued again.

Ports:
- clk  input  1  single clock. All logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  8  value being monitored, sampled every posedge.
- in_cnt  input  8  upstream stability count. 0 means the value just changed. Wraps 255->0.
- out_data  output  8  stable value at the FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both 1 at a posedge.
- drop_cnt  output  8  count of stable events lost because the FIFO was full. Saturates at 255.
- fifo_level  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Synchronous, active-high reset: rst=1 at a posedge overrides everything.
  - Reset values: out_valid=0, out_data=0, drop_cnt=0, fifo_level=0.
  - Internal state: FSM in ARM, last_reported=0, has_reported=0.
  - Reset during operation discards all queued entries.
- FSM, 2 states:
  - ARM: waiting for the threshold. If in_cnt==STABLE_CNT, a stable event fires and the FSM goes to WAIT_CHANGE. Otherwise it stays in ARM.
  - WAIT_CHANGE: the current run has been reported. If in_cnt==0, go to ARM. No events fire in this state.
  - If in_cnt==0 while in ARM, stay in ARM.
- Counter wrap-around (255->0 while the value is unchanged) re-arms the FSM. A second event can then fire at STABLE_CNT; with DEDUP=1 it is suppressed because the value matches last_reported.
- Stable event handling:
  - Candidate is in_val as sampled in the event cycle.
  - With DEDUP=1, the event is suppressed (no push, no drop count) when has_reported=1 and in_val==last_reported.
  - When not suppressed, last_reported<=in_val and has_reported<=1, regardless of whether the push succeeds.
- FIFO:
  - Circular buffer with read/write pointers.
  - push = unsuppressed event; pop = out_valid & out_ready.
  - out_data is the head entry, valid when out_valid=1, and is held stable while out_valid=1 and out_ready=0.
- Latency: an event in cycle N with the FIFO empty gives out_valid=1 and out_data=in_val after posedge N, i.e. visible in cycle N+1. There is no combinational path from in_* to out_*.
- Full FIFO:
  - If push occurs with no pop in the same cycle, the push is dropped and drop_cnt increments, saturating at 255.
  - If push and pop occur in the same cycle, both complete, the level is unchanged and nothing is dropped.
- Empty FIFO: out_ready is ignored. The level never goes below 0.
- Push and pop together at any non-full level: the level is unchanged and ordering is preserved (strict FIFO).
- fifo_level = pushes accepted - pops, and always satisfies 0 <= fifo_level <= DEPTH.

Test Plan (defaults STABLE_CNT=3, DEPTH=4, DEDUP=1 unless noted):
1. Basic event: after rst, in_val=8'h11 with in_cnt=0,1,2,3 on successive clocks, out_ready=0 -> out_valid=1 and out_data=8'h11 the cycle after in_cnt=3, fifo_level=1. Further in_cnt=4,5 -> no new push.
2. Full FIFO and drop: out_ready=0, stabilise 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 in turn (in_cnt 0..3 each) -> fifo_level=4, drop_cnt=1. Then out_ready=1 -> drains 01,02,03,04 in order, out_valid=0 afterwards.
3. Deduplication: stabilise 8'hA5, change to 8'h3C (cnt 0,1 only), return to 8'hA5 and stabilise -> exactly one 8'hA5 entry. Same stimulus with DEDUP=0 -> two 8'hA5 entries.
4. Wrap-around: hold 8'h77 with in_cnt running 0..255,0..3 -> one entry with DEDUP=1; two entries with DEDUP=0.
5. Simultaneous push and pop at full: FIFO holding 4 entries, out_ready=1 in the same cycle as a new event (8'h99) -> fifo_level stays 4, drop_cnt unchanged, 8'h99 is drained last.
6. Reset mid-operation: fifo_level=3 and drop_cnt=2, assert rst for 1 cycle -> out_valid=0, out_data=0, fifo_level=0, drop_cnt=0. Next stable event (in_val=8'h00) is queued because has_reported was cleared.
